// File: rtl/pe_seq_pkg.sv
// Shared types and schedule tables for the bit-brick PE job sequencer.
package pe_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [1:0] mode_t;

    localparam int RD_LAT = 1;
    localparam int PROD_W = 19;
    localparam int PASS_W = 3;

    function automatic logic [PASS_W-1:0] pass_cnt(mode_t m);
        case (m)
            2'd0:    return 3'd1;
            2'd1:    return 3'd3;
            2'd2:    return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    // Every mode runs a prefix of the same shift sequence, so only the pass index matters.
    function automatic logic [3:0] shift_code(logic [PASS_W-1:0] p);
        case (p)
            3'd0:    return 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd6;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/pe_seq_acc.sv
// Gated accumulator for PE products; saturates with a sticky flag when PE_SEQ_SATURATE_EN is defined.
module pe_seq_acc #(
    parameter int ACC_W  = 32,
    parameter int PROD_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_acc
`ifdef PE_SEQ_SATURATE_EN
    , output logic            o_sat
`endif
);

    logic [ACC_W-1:0] acc_q, acc_d;

`ifdef PE_SEQ_SATURATE_EN
    logic           sat_q, sat_d;
    logic [ACC_W:0] sum;

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        // One guard bit: overflow shows up as disagreement between the top two bits.
        sum   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){i_prod[PROD_W-1]}}, i_prod};
        if (i_clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (i_en) begin
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                sat_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sat_q <= 1'b0;
        else          sat_q <= sat_d;
    end

    assign o_sat = sat_q;
`else
    always_comb begin
        acc_d = acc_q;
        if (i_clr)     acc_d = '0;
        else if (i_en) acc_d = acc_q + {{(ACC_W-PROD_W){i_prod[PROD_W-1]}}, i_prod};
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Job sequencer for one bit-brick PE: issues operand reads per pass and accumulates the PE result.
// Optional PE_SEQ_SATURATE_EN: saturating accumulator plus sticky o_res_sat output.
//
// state    | meaning
// ST_IDLE  | ready for a job, acc cleared on accept
// ST_RUN   | one operand read per cycle, len x passes issues
// ST_DRAIN | waiting for the last products to reach the accumulator
// ST_DONE  | result held on o_res_data until taken
module pe_seq_ctrl
    import pe_seq_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_mode,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic [ADDR_W-1:0] i_cmd_base,
    input  logic              i_cmd_a_signed,
    input  logic              i_cmd_w_signed,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [31:0]       i_rd_act,
    input  logic [31:0]       i_rd_wgt,
    output logic [31:0]       o_pe_activation,
    output logic [31:0]       o_pe_weight,
    output logic              o_pe_A_signed,
    output logic              o_pe_W_signed,
    output logic [3:0]        o_pe_shift,
    input  logic [PROD_W-1:0] i_pe_prod,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [ACC_W-1:0]  o_res_data,
    output logic              o_busy
`ifdef PE_SEQ_SATURATE_EN
    , output logic            o_res_sat
`endif
);

    state_e              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    elem_q, elem_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                a_sgn_q, a_sgn_d;
    logic                w_sgn_q, w_sgn_d;
    logic [3:0]          shift_q, shift_d;
    logic [RD_LAT:0]     vpipe_q, vpipe_d;
    logic                issue;
    logic                acc_clr;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        elem_d      = elem_q;
        pass_d      = pass_q;
        addr_d      = addr_q;
        a_sgn_d     = a_sgn_q;
        w_sgn_d     = w_sgn_q;
        shift_d     = 4'd0;
        issue       = 1'b0;
        acc_clr     = 1'b0;
        o_cmd_ready = 1'b0;
        o_rd_en     = 1'b0;
        o_rd_addr   = '0;
        o_res_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    mode_d  = i_cmd_mode;
                    len_d   = i_cmd_len;
                    addr_d  = i_cmd_base;
                    a_sgn_d = i_cmd_a_signed;
                    w_sgn_d = i_cmd_w_signed;
                    elem_d  = '0;
                    pass_d  = '0;
                    acc_clr = 1'b1;
                    state_d = (i_cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                o_rd_en   = 1'b1;
                o_rd_addr = addr_q;
                issue     = 1'b1;
                shift_d   = shift_code(pass_q);
                addr_d    = addr_q + ADDR_W'(1);
                if (pass_q == pass_cnt(mode_q) - PASS_W'(1)) begin
                    pass_d = '0;
                    if (elem_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
                    else                             elem_d  = elem_q + LEN_W'(1);
                end else begin
                    pass_d = pass_q + PASS_W'(1);
                end
            end
            ST_DRAIN: begin
                // Leave once only the final product is left in flight; it lands on this edge.
                if (vpipe_q[RD_LAT-1:0] == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_res_valid = 1'b1;
                if (i_res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        vpipe_d = {vpipe_q[RD_LAT-1:0], issue};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            elem_q  <= '0;
            pass_q  <= '0;
            addr_q  <= '0;
            a_sgn_q <= 1'b0;
            w_sgn_q <= 1'b0;
            shift_q <= 4'd0;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            elem_q  <= elem_d;
            pass_q  <= pass_d;
            addr_q  <= addr_d;
            a_sgn_q <= a_sgn_d;
            w_sgn_q <= w_sgn_d;
            shift_q <= shift_d;
            vpipe_q <= vpipe_d;
        end
    end

    assign o_pe_activation = i_rd_act;
    assign o_pe_weight     = i_rd_wgt;
    assign o_pe_A_signed   = a_sgn_q;
    assign o_pe_W_signed   = w_sgn_q;
    assign o_pe_shift      = shift_q;
    assign o_busy          = (state_q != ST_IDLE);

    pe_seq_acc #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (acc_clr),
        .i_en    (vpipe_q[RD_LAT]),
        .i_prod  (i_pe_prod),
        .o_acc   (o_res_data)
`ifdef PE_SEQ_SATURATE_EN
        , .o_sat (o_res_sat)
`endif
    );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl with a behavioural operand buffer and bit-brick PE.
module tb_pe_seq_ctrl;

    localparam int ACC_W  = 24;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 9;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef PE_SEQ_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic [1:0]        i_cmd_mode = '0;
    logic [LEN_W-1:0]  i_cmd_len = '0;
    logic [ADDR_W-1:0] i_cmd_base = '0;
    logic              i_cmd_a_signed = 1'b0;
    logic              i_cmd_w_signed = 1'b0;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [31:0]       i_rd_act = '0;
    logic [31:0]       i_rd_wgt = '0;
    logic [31:0]       o_pe_activation;
    logic [31:0]       o_pe_weight;
    logic              o_pe_A_signed;
    logic              o_pe_W_signed;
    logic [3:0]        o_pe_shift;
    logic [18:0]       i_pe_prod = '0;
    logic              o_res_valid;
    logic              i_res_ready = 1'b0;
    logic [ACC_W-1:0]  o_res_data;
    logic              o_busy;
    logic              res_sat;

    pe_seq_ctrl #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_mode      (i_cmd_mode),
        .i_cmd_len       (i_cmd_len),
        .i_cmd_base      (i_cmd_base),
        .i_cmd_a_signed  (i_cmd_a_signed),
        .i_cmd_w_signed  (i_cmd_w_signed),
        .o_rd_en         (o_rd_en),
        .o_rd_addr       (o_rd_addr),
        .i_rd_act        (i_rd_act),
        .i_rd_wgt        (i_rd_wgt),
        .o_pe_activation (o_pe_activation),
        .o_pe_weight     (o_pe_weight),
        .o_pe_A_signed   (o_pe_A_signed),
        .o_pe_W_signed   (o_pe_W_signed),
        .o_pe_shift      (o_pe_shift),
        .i_pe_prod       (i_pe_prod),
        .o_res_valid     (o_res_valid),
        .i_res_ready     (i_res_ready),
        .o_res_data      (o_res_data),
        .o_busy          (o_busy)
`ifdef PE_SEQ_SATURATE_EN
        , .o_res_sat     (res_sat)
`endif
    );
`ifndef PE_SEQ_SATURATE_EN
    assign res_sat = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    typedef struct {
        longint res;
        bit     sat;
        int     lat;
        int     nrd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] act_mem [DEPTH];
    logic [31:0] wgt_mem [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;
    int          rd_cnt = 0;
    bit          rd_prev = 1'b0;
    int          addr_log[$];
    int          shift_log[$];

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic int n_pass(input int m);
        case (m)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int shift_of(input int p);
        case (p)
            0:       return 0;
            1:       return 2;
            2:       return 4;
            3:       return 6;
            default: return 10;
        endcase
    endfunction

    function automatic longint pe_fn(input logic [31:0] a, input logic [31:0] w,
                                     input bit as, input bit ws, input int sh);
        longint s = 0;
        for (int i = 0; i < 16; i++) begin
            int av = int'(a[2*i +: 2]);
            int wv = int'(w[2*i +: 2]);
            if (as && av >= 2) av -= 4;
            if (ws && wv >= 2) wv -= 4;
            s += longint'(av * wv);
        end
        return s * (longint'(1) << sh);
    endfunction

    function automatic logic [18:0] pe_reg(input logic [31:0] a, input logic [31:0] w,
                                           input bit as, input bit ws, input int sh);
        longint v = pe_fn(a, w, as, ws, sh);
        return v[18:0];
    endfunction

    // Operand buffer: one cycle read latency.
    always @(posedge i_clk) begin
        if (o_rd_en) begin
            i_rd_act <= act_mem[o_rd_addr];
            i_rd_wgt <= wgt_mem[o_rd_addr];
        end
    end

    // Bit-brick PE with registered product.
    always @(posedge i_clk) begin
        i_pe_prod <= pe_reg(o_pe_activation, o_pe_weight, o_pe_A_signed, o_pe_W_signed, int'(o_pe_shift));
    end

    always @(negedge i_clk) begin
        if (rd_prev) shift_log.push_back(int'(o_pe_shift));
        if (o_rd_en) begin
            rd_cnt++;
            addr_log.push_back(int'(o_rd_addr));
        end
        rd_prev = o_rd_en;
    end

    function automatic exp_t job_model(input int m, input int len, input int base,
                                       input bit as, input bit ws);
        exp_t   e;
        longint acc = 0;
        longint maxv = (longint'(1) << (ACC_W-1)) - 1;
        longint minv = -(longint'(1) << (ACC_W-1));
        int     np = n_pass(m);
        e.sat = 1'b0;
        for (int el = 0; el < len; el++) begin
            for (int p = 0; p < np; p++) begin
                int     ad = (base + el*np + p) % DEPTH;
                longint pr = pe_fn(act_mem[ad], wgt_mem[ad], as, ws, shift_of(p));
                acc = acc + pr;
                if (SAT) begin
                    if (acc > maxv) begin acc = maxv; e.sat = 1'b1; end
                    if (acc < minv) begin acc = minv; e.sat = 1'b1; end
                end else begin
                    acc = acc & ((longint'(1) << ACC_W) - 1);
                    if (acc > maxv) acc = acc - (longint'(1) << ACC_W);
                end
            end
        end
        e.res = acc;
        e.nrd = len * np;
        e.lat = (len == 0) ? 1 : e.nrd + 3;
        return e;
    endfunction

    task automatic drive_cmd(input int m, input int len, input int base, input bit as, input bit ws);
        rd_cnt = 0;
        addr_log.delete();
        shift_log.delete();
        check("cmd_ready", longint'(o_cmd_ready), 1);
        i_cmd_mode     = 2'(m);
        i_cmd_len      = LEN_W'(len);
        i_cmd_base     = ADDR_W'(base);
        i_cmd_a_signed = as;
        i_cmd_w_signed = ws;
        i_cmd_valid    = 1'b1;
        exp_q.push_back(job_model(m, len, base, as, ws));
        @(posedge i_clk);
        #1;
        i_cmd_valid    = 1'b0;
        i_cmd_mode     = 2'($urandom_range(0, 3));
        i_cmd_len      = LEN_W'($urandom_range(0, 256));
        i_cmd_base     = ADDR_W'($urandom);
        i_cmd_a_signed = 1'($urandom);
        i_cmd_w_signed = 1'($urandom);
    endtask

    task automatic run_job(input int m, input int len, input int base,
                           input bit as, input bit ws, input int hold);
        exp_t e;
        int   cyc;
        drive_cmd(m, len, base, as, ws);
        @(negedge i_clk);
        cyc = 1;
        while (!o_res_valid && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
        end
        if (!o_res_valid) begin
            check("res_timeout", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        check("res_data", longint'($signed(o_res_data)), e.res);
        check("res_cycle", cyc, e.lat);
        check("rd_count", rd_cnt, e.nrd);
        if (SAT) check("res_sat", longint'(res_sat), longint'(e.sat));
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clk);
            check("hold_valid", longint'(o_res_valid), 1);
            check("hold_data", longint'($signed(o_res_data)), e.res);
        end
        i_res_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_res_ready = 1'b0;
        @(negedge i_clk);
        check("post_idle", longint'({o_cmd_ready, o_res_valid, o_busy}), 4);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            act_mem[i] = 32'h5555_5555;
            wgt_mem[i] = 32'h5555_5555;
        end
        #2;
        check("rst_ready", longint'(o_cmd_ready), 1);
        check("rst_busy", longint'(o_busy), 0);
        check("rst_rd", longint'({o_rd_en, o_rd_addr}), 0);
        check("rst_pe", longint'({o_pe_shift, o_pe_A_signed, o_pe_W_signed}), 0);
        check("rst_res", longint'({o_res_valid, o_res_data, res_sat}), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_job(0, 1, 0, 1'b0, 1'b0, 0);

        act_mem[5] = 32'hFFFF_FFFF;
        run_job(0, 1, 5, 1'b1, 1'b1, 0);

        run_job(1, 2, 100, 1'b0, 1'b0, 0);
        check("log_sizes", longint'({addr_log.size(), shift_log.size()}), longint'({32'd6, 32'd6}));
        for (int i = 0; i < 6 && i < addr_log.size() && i < shift_log.size(); i++) begin
            check("rd_addr", addr_log[i], 100 + i);
            check("pe_shift", shift_log[i], shift_of(i % 3));
        end

        run_job(0, 0, 7, 1'b0, 1'b0, 2);

        for (int i = 0; i < DEPTH; i++) begin
            act_mem[i] = 32'hFFFF_FFFF;
            wgt_mem[i] = 32'hFFFF_FFFF;
        end
        run_job(3, 256, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i < DEPTH; i++) begin
            act_mem[i] = $urandom;
            wgt_mem[i] = $urandom;
        end
        run_job(2, 7, 1020, 1'b1, 1'b0, 1);
        run_job(3, 3, 40, 1'b1, 1'b1, 0);
        run_job(1, 5, 300, 1'b0, 1'b1, 0);

        for (int i = 0; i < 16; i++) begin
            act_mem[i] = 32'h5555_5555;
            wgt_mem[i] = 32'h5555_5555;
        end
        drive_cmd(3, 10, 0, 1'b0, 1'b0);
        repeat (5) @(negedge i_clk);
        check("mid_busy", longint'({o_busy, o_rd_en}), 3);
        i_rst_n = 1'b0;
        #1;
        check("mrst_state", longint'({o_busy, o_rd_en, o_res_valid, o_cmd_ready}), 1);
        check("mrst_res", longint'(o_res_data), 0);
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run_job(0, 1, 0, 1'b0, 1'b0, 5);
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_seq_ctrl.md
# pe_seq_ctrl

Job sequencer for one bit-brick PE (16 × 2-bit brick multiplier with a shared post-sum shift). It accepts a dot-product job, fetches pre-packed activation/weight words from the operand buffer, and drives the PE operands, signedness and shift code for every pass. It also accumulates the PE's registered 19-bit result and returns one signed sum per job over a valid/ready handshake. It sits between the layer control FSM and a single PE instance.

## Interface
- ACC_W, 32: accumulator and result width (≥ 20)
- ADDR_W, 10: operand buffer word address width
- LEN_W, 9: job length field width; legal lengths are 0..256
---
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_cmd_valid / o_cmd_ready  in/out  1  job handshake
- i_cmd_mode  in  2  precision mode; selects the pass schedule
- i_cmd_len  in  LEN_W  element count
- i_cmd_base  in  ADDR_W  first operand word address
- i_cmd_a_signed, i_cmd_w_signed  in  1  operand signedness
- o_rd_en  out  1  operand buffer read strobe
- o_rd_addr  out  ADDR_W  word address
- i_rd_act, i_rd_wgt  in  32  read data; arrives 1 cycle after o_rd_en
- o_pe_activation, o_pe_weight  out  32  PE operands
- o_pe_A_signed, o_pe_W_signed  out  1  PE signedness
- o_pe_shift  out  4  PE shift code
- i_pe_prod  in  19  PE registered signed product
- o_res_valid / i_res_ready  out/in  1  result handshake
- o_res_data  out  ACC_W  signed sum
- o_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - o_cmd_ready = 1.
  - On accept, latch mode, length, base and signedness, and clear acc.
  - If len = 0, go to DONE with result 0. Otherwise go to RUN.
- Pass schedule (shift codes):
  - mode 0: {0}
  - mode 1: {0,2,4}
  - mode 2: {0,2,4,6}
  - mode 3: {0,2,4,6,10}
  - P = number of passes; N = len × P issues.
- RUN:
  - Each cycle: o_rd_en = 1 and o_rd_addr = base + issue index. The address wraps modulo 2^ADDR_W.
  - Words are stored element-major, then pass-major.
  - The pass counter wraps at P−1, then the element counter increments.
  - After the Nth issue, go to DRAIN.
- Operands: o_pe_activation/o_pe_weight = i_rd_act/i_rd_wgt, combinational pass-through. o_pe_shift is registered and aligned with the data cycle.
- Valid pipe: a 2-stage valid pipe follows each issue. acc += sign-extended i_pe_prod only when stage 2 is set. PE output in all other cycles is ignored.
- DRAIN: lasts 2 cycles, until the valid pipe is empty. Then go to DONE.
- DONE:
  - o_res_valid = 1 and o_res_data = acc, both stable until i_res_ready.
  - On handshake, return to IDLE. No new command is accepted in the handshake cycle.
- Command fields change while busy: ignored.
- Reset mid-job: immediately return to IDLE. Counters, acc and the valid pipe are cleared. Any pending result is lost.

## Timing
- Reset values:
  - o_cmd_ready = 1
  - o_busy = 0
  - o_rd_en = 0, o_rd_addr = 0
  - o_pe_shift = 0, o_pe_A_signed = 0, o_pe_W_signed = 0
  - o_res_valid = 0, o_res_data = 0
- Accept at edge 0. Reads occur in cycles 1..N. The PE consumes data in cycles 2..N+1. Accumulation happens at the ends of cycles 3..N+2.
- o_res_valid rises in cycle N+3.
- len = 0: o_res_valid rises in cycle 1.
- Throughput: one PE pass per cycle, with no bubbles within a job. Job-to-job overhead is 4 cycles plus the result wait.

## Configuration
- PE_SEQ_SATURATE_EN defined: the accumulator saturates at ±(2^(ACC_W−1)) bounds. The extra output o_res_sat (1 bit) is sticky per job and is reset to 0.
- PE_SEQ_SATURATE_EN undefined: the accumulator wraps two's-complement, and o_res_sat is absent.

## Structure
- Package pe_seq_pkg holds:
  - the state enum
  - the mode type
  - the pass-count table
  - the shift-code table (legal codes are 0, 2, 4, 6 and 10 only)
  - the latency constant RD_LAT = 1
- Sub-module pe_seq_acc: the gated, optionally saturating accumulator.

## Test plan
- mode 0, len 1, unsigned, act = wgt = 0x55555555 → result 16, o_res_valid in cycle 4.
- mode 0, len 1, both signed, act 0xFFFFFFFF, wgt 0x55555555 → result −16.
- mode 1, len 2, unsigned, all words 0x55555555 → six reads at base..base+5, shifts 0,2,4,0,2,4, result 672.
- len 0 → result 0 in cycle 1, with no o_rd_en pulses.
- Cases:
  - ACC_W = 24 with macro, mode 3, len 256, unsigned, all words 0xFFFFFFFF → result 8388607, o_res_sat = 1.
  - Same job without the macro → wrapped value 40882176 mod 2^24 = 7327744 (positive).
- Reset asserted mid-RUN, then a new mode 0 job → clean result 16. i_res_ready held low 5 cycles → o_res_data stable throughout.
